// File: rtl/fp_norm_shifter_if.sv
// Handshake bundle for fp_norm_shifter: operand side (in_*) and result side (out_*).
// The producer/consumer environment uses master; the shifter uses slave.
interface fp_norm_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_trail;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_cnt;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_trail, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_trail, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_zero
  );
endinterface

// File: rtl/fp_norm_shifter.sv
// Multi-cycle leading/trailing-one normalizer: binary-search shift, one stage per clock,
// fixed latency of log2(WIDTH) edges from accept to result.
module fp_norm_shifter #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_norm_shifter_if.slave  io
);
  localparam int STAGES = $clog2(WIDTH);
  localparam int CW     = $clog2(WIDTH) + 1;
  localparam int KW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic             trail_q, trail_d;
  logic             zero_q, zero_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      trail_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      trail_q <= trail_d;
      zero_q  <= zero_d;
    end
  end

  logic [WIDTH-1:0] ones;
  logic [CW-1:0]    step;
  logic             hit;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    trail_d = trail_q;
    zero_d  = zero_q;
    ones    = '1;
    step    = CW'(1) << k_q;
    hit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          data_d  = io.in_data;
          trail_d = io.in_trail;
          zero_d  = (io.in_data == '0);
          cnt_d   = '0;
          k_d     = KW'(STAGES - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A stage shifts only when the whole window of 'step' bits at the far end is empty.
        if (trail_q) begin
          hit = ((data_q & ~(ones << step)) == '0);
          if (hit) data_d = data_q >> step;
        end else begin
          hit = ((data_q & ~(ones >> step)) == '0);
          if (hit) data_d = data_q << step;
        end
        if (hit) cnt_d = cnt_q + step;
        if (k_q == '0) begin
          state_d = DONE;
          if (zero_q) begin
            cnt_d  = CW'(WIDTH);
            data_d = '0;
          end
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = data_q;
  assign io.out_cnt   = cnt_q;
  assign io.out_zero  = zero_q;
endmodule

// File: tb/tb_fp_norm_shifter.sv
// Directed plus random bench for fp_norm_shifter; expected results come from a
// linear-scan LZC/TZC reference model queued at send time and popped at each result.
module tb_fp_norm_shifter;
  localparam int WIDTH = 32;
  localparam int CW    = 6;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    cnt;
    logic             zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_norm_shifter_if #(.WIDTH(WIDTH)) bus ();

  fp_norm_shifter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t refModel(input logic [WIDTH-1:0] d, input logic t);
    exp_t r;
    int   n;
    n = 0;
    if (d == '0) begin
      r.data = '0;
      r.cnt  = CW'(WIDTH);
      r.zero = 1'b1;
    end else begin
      if (!t) while (!d[WIDTH-1-n]) n++;
      else    while (!d[n]) n++;
      r.data = t ? (d >> n) : (d << n);
      r.cnt  = CW'(n);
      r.zero = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic t);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    checkValue("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_trail = t;
    sb.push_back(refModel(d, t));
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_trail = 1'($urandom_range(0, 1));
  endtask

  task automatic waitValid(input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkValue({tag, "_latency"}, 32'(lat), 32'd5);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL %s_scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      checkValue({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      checkValue({tag, "_data"},  32'(bus.out_data),  32'(e.data));
      checkValue({tag, "_cnt"},   32'(bus.out_cnt),   32'(e.cnt));
      checkValue({tag, "_zero"},  32'(bus.out_zero),  32'(e.zero));
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkValue("idle_in_ready",  32'(bus.in_ready),  32'd1);
    checkValue("idle_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic runTxn(input logic [WIDTH-1:0] d, input logic t, input string tag);
    applyStimulus(d, t);
    waitValid(tag);
    checkOutput(tag);
    handshake();
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             t;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_trail  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checkValue("rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkValue("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("rst_out_data",  32'(bus.out_data),  32'd0);
    checkValue("rst_out_cnt",   32'(bus.out_cnt),   32'd0);
    checkValue("rst_out_zero",  32'(bus.out_zero),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    runTxn(32'h0000_0001, 1'b0, "lead_one");
    runTxn(32'h00F0_0000, 1'b0, "lead_f0");
    runTxn(32'h00F0_0000, 1'b1, "trail_f0");
    runTxn(32'h0000_0000, 1'b0, "lead_zero");
    runTxn(32'h0000_0000, 1'b1, "trail_zero");
    runTxn(32'h8000_0000, 1'b0, "lead_norm");
    runTxn(32'h0000_0001, 1'b1, "trail_norm");

    // Backpressure: result must hold while extra operands are offered and ignored.
    applyStimulus(32'h00F0_0000, 1'b0);
    waitValid("hold");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      tick();
      checkValue("hold_valid", 32'(bus.out_valid), 32'd1);
      checkValue("hold_ready", 32'(bus.in_ready),  32'd0);
      checkValue("hold_data",  32'(bus.out_data),  32'hF000_0000);
      checkValue("hold_cnt",   32'(bus.out_cnt),   32'd8);
    end
    bus.in_valid = 1'b0;
    checkOutput("hold");
    handshake();
    runTxn(32'h0000_0300, 1'b1, "after_hold");

    // Abort in the middle of the shift sequence.
    applyStimulus(32'h0000_1234, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checkValue("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("abort_in_ready",  32'(bus.in_ready),  32'd1);
    checkValue("abort_out_data",  32'(bus.out_data),  32'd0);
    checkValue("abort_out_cnt",   32'(bus.out_cnt),   32'd0);
    checkValue("abort_out_zero",  32'(bus.out_zero),  32'd0);
    void'(sb.pop_back());
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkValue("abort_no_result", 32'(bus.out_valid), 32'd0);
    end
    runTxn(32'h0001_0000, 1'b0, "post_abort");

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d = d >> $urandom_range(0, 31);
        1: d = d << $urandom_range(0, 31);
        2: d = 32'h1 << $urandom_range(0, 31);
        default: ;
      endcase
      t = 1'($urandom_range(0, 1));
      applyStimulus(d, t);
      waitValid("rand");
      repeat ($urandom_range(0, 3)) tick();
      checkOutput("rand");
      handshake();
    end

    checkValue("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
